// File: rtl/cond_pkg.sv
// Shared types for the execute-stage condition unit: condition-code encoding
// and NZCV bit positions.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: condition code plus NZCV gives the pass bit.
module cond_check
    import cond_pkg::*;
(
    input  cond_t      cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV register, condition gating of the E->M controls.
// Define COND_SQUASH_CNT_EN to add the saturating squash counter and its port.
module cond_unit
    import cond_pkg::*;
`ifdef COND_SQUASH_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid_e,
    input  logic       stall_e,
    input  logic       flush_e,
    input  logic [3:0] cond_e,
    input  logic [1:0] flag_w_e,
    input  logic [3:0] alu_flags_e,
    input  logic       pcs_e,
    input  logic       reg_w_e,
    input  logic       mem_w_e,
    input  logic       no_write_e,
    output logic       cond_ex_e,
    output logic [3:0] flags_q,
    output logic       valid_m,
    output logic       pcs_m,
    output logic       reg_write_m,
    output logic       mem_write_m
`ifdef COND_SQUASH_CNT_EN
    ,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    logic commit;
    logic pass_v;

    cond_check u_check (
        .cond  (cond_t'(cond_e)),
        .flags (flags_q),
        .pass  (cond_ex_e)
    );

    assign pass_v = valid_e & cond_ex_e;
    assign commit = pass_v & ~stall_e & ~flush_e;

    // Flags only move on a committed instruction; stall and flush both block it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else if (commit) begin
            if (flag_w_e[1]) flags_q[3:2] <= alu_flags_e[3:2];
            if (flag_w_e[0]) flags_q[1:0] <= alu_flags_e[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_m     <= 1'b0;
            pcs_m       <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
        end else if (flush_e) begin
            valid_m     <= 1'b0;
            pcs_m       <= 1'b0;
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
        end else if (!stall_e) begin
            valid_m     <= valid_e;
            pcs_m       <= pass_v & pcs_e;
            reg_write_m <= pass_v & reg_w_e & ~no_write_e;
            mem_write_m <= pass_v & mem_w_e;
        end
    end

`ifdef COND_SQUASH_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            squash_cnt <= '0;
        end else if (valid_e & ~cond_ex_e & ~stall_e & ~flush_e & (squash_cnt != '1)) begin
            squash_cnt <= squash_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with hand-computed expectations.
// Squash-counter checks are compiled in only when COND_SQUASH_CNT_EN is defined.
module tb_cond_unit;

   logic       clk;
   logic       reset_n;
   logic       valid_e, stall_e, flush_e;
   logic [3:0] cond_e;
   logic [1:0] flag_w_e;
   logic [3:0] alu_flags_e;
   logic       pcs_e, reg_w_e, mem_w_e, no_write_e;
   logic       cond_ex_e;
   logic [3:0] flags_q;
   logic       valid_m, pcs_m, reg_write_m, mem_write_m;
`ifdef COND_SQUASH_CNT_EN
   logic [3:0] squash_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

`ifdef COND_SQUASH_CNT_EN
   cond_unit #(.CNT_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_e     (valid_e),
      .stall_e     (stall_e),
      .flush_e     (flush_e),
      .cond_e      (cond_e),
      .flag_w_e    (flag_w_e),
      .alu_flags_e (alu_flags_e),
      .pcs_e       (pcs_e),
      .reg_w_e     (reg_w_e),
      .mem_w_e     (mem_w_e),
      .no_write_e  (no_write_e),
      .cond_ex_e   (cond_ex_e),
      .flags_q     (flags_q),
      .valid_m     (valid_m),
      .pcs_m       (pcs_m),
      .reg_write_m (reg_write_m),
      .mem_write_m (mem_write_m),
      .squash_cnt  (squash_cnt)
   );
`else
   cond_unit dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_e     (valid_e),
      .stall_e     (stall_e),
      .flush_e     (flush_e),
      .cond_e      (cond_e),
      .flag_w_e    (flag_w_e),
      .alu_flags_e (alu_flags_e),
      .pcs_e       (pcs_e),
      .reg_w_e     (reg_w_e),
      .mem_w_e     (mem_w_e),
      .no_write_e  (no_write_e),
      .cond_ex_e   (cond_ex_e),
      .flags_q     (flags_q),
      .valid_m     (valid_m),
      .pcs_m       (pcs_m),
      .reg_write_m (reg_write_m),
      .mem_write_m (mem_write_m)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // M register packed as {valid, pcs, reg_write, mem_write}
   function automatic logic [7:0] mreg();
      return {4'b0, valid_m, pcs_m, reg_write_m, mem_write_m};
   endfunction

   task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic [3:0] af, input logic p, input logic rw,
                        input logic mw, input logic nw, input logic st, input logic fl);
      valid_e = v; cond_e = c; flag_w_e = fw; alu_flags_e = af;
      pcs_e = p; reg_w_e = rw; mem_w_e = mw; no_write_e = nw;
      stall_e = st; flush_e = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("rst_flags", {4'b0, flags_q}, 8'h00);
      check("rst_mreg", mreg(), 8'h00);
`ifdef COND_SQUASH_CNT_EN
      check("rst_squash", {4'b0, squash_cnt}, 8'h00);
`endif
      check("rst_eq", {7'b0, cond_ex_e}, 8'h00);
      drive(0, 4'h1, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("rst_ne", {7'b0, cond_ex_e}, 8'h01);
      drive(0, 4'hF, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("rst_nv", {7'b0, cond_ex_e}, 8'h00);

      @(posedge clk); #1;
      reset_n = 1'b1;

      // flag-setting SUB producing Z
      drive(1, 4'hE, 2'b11, 4'h4, 0, 0, 0, 0, 0, 0);
      check("sub_condex", {7'b0, cond_ex_e}, 8'h01);
      tick();
      check("sub_flags", {4'b0, flags_q}, 8'h04);
      check("sub_mreg", mreg(), 8'h08);

      // EQ right after the setter sees Z with no bypass
      drive(1, 4'h0, 2'b00, 4'h0, 1, 1, 0, 0, 0, 0);
      check("eq_condex", {7'b0, cond_ex_e}, 8'h01);
      tick();
      check("eq_mreg", mreg(), 8'h0E);

      drive(1, 4'h0, 2'b00, 4'h0, 0, 1, 1, 1, 0, 0);
      tick();
      check("nowrite_mreg", mreg(), 8'h09);

      // all flags set, then compound conditions
      drive(1, 4'hE, 2'b11, 4'hF, 0, 0, 0, 0, 0, 0);
      tick();
      check("set_all", {4'b0, flags_q}, 8'h0F);
      drive(0, 4'hA, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("ge_1111", {7'b0, cond_ex_e}, 8'h01);
      drive(0, 4'hB, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("lt_1111", {7'b0, cond_ex_e}, 8'h00);
      drive(0, 4'h8, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("hi_1111", {7'b0, cond_ex_e}, 8'h00);
      drive(0, 4'h9, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("ls_1111", {7'b0, cond_ex_e}, 8'h01);
      drive(0, 4'hC, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("gt_1111", {7'b0, cond_ex_e}, 8'h00);
      drive(0, 4'hD, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("le_1111", {7'b0, cond_ex_e}, 8'h01);
      drive(0, 4'h7, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      check("vc_1111", {7'b0, cond_ex_e}, 8'h00);

      // partial write: only N,Z
      drive(1, 4'hE, 2'b10, 4'h0, 0, 0, 0, 0, 0, 0);
      tick();
      check("partial_nz", {4'b0, flags_q}, 8'h03);
      drive(1, 4'hE, 2'b01, 4'hC, 0, 0, 0, 0, 0, 0);
      tick();
      check("partial_cv", {4'b0, flags_q}, 8'h00);

      // failed condition must not write flags or memory
      drive(1, 4'h0, 2'b11, 4'h8, 0, 0, 1, 0, 0, 0);
      check("fail_condex", {7'b0, cond_ex_e}, 8'h00);
      tick();
      check("fail_mreg", mreg(), 8'h08);
      check("fail_flags", {4'b0, flags_q}, 8'h00);
`ifdef COND_SQUASH_CNT_EN
      check("fail_squash", {4'b0, squash_cnt}, 8'h01);
`endif

      drive(1, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0);
      tick();
      check("pre_stall_mreg", mreg(), 8'h0A);

      // stall holds M and flags even for a flag-setting AL
      drive(1, 4'hE, 2'b11, 4'hF, 0, 0, 1, 0, 1, 0);
      tick();
      check("stall_mreg", mreg(), 8'h0A);
      check("stall_flags", {4'b0, flags_q}, 8'h00);

      // flush beats stall
      drive(1, 4'hE, 2'b11, 4'hF, 1, 1, 1, 0, 1, 1);
      tick();
      check("flush_mreg", mreg(), 8'h00);
      check("flush_flags", {4'b0, flags_q}, 8'h00);

      // async reset mid-cycle
      drive(1, 4'hE, 2'b11, 4'hA, 1, 0, 0, 0, 0, 0);
      tick();
      check("pre_arst_flags", {4'b0, flags_q}, 8'h0A);
      check("pre_arst_mreg", mreg(), 8'h0C);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_flags", {4'b0, flags_q}, 8'h00);
      check("arst_mreg", mreg(), 8'h00);
      @(posedge clk); #1;
      reset_n = 1'b1;

`ifdef COND_SQUASH_CNT_EN
      check("arst_squash", {4'b0, squash_cnt}, 8'h00);
      drive(1, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) tick();
      check("squash_sat", {4'b0, squash_cnt}, 8'h0F);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
